// File: rtl/serial_word_collector_pkg.sv
// Shared types and constants for the serial word collector and its popcount neighbour.
package serial_word_collector_pkg;

  localparam int W_DEFAULT = 7;
  localparam int POP_W     = $clog2(W_DEFAULT + 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_PARITY  = 2'd1,
    ST_HOLD    = 2'd2
  } st_t;

endpackage

// File: rtl/serial_word_collector.sv
// Serial-to-parallel collector: MSB-first bit stream in, registered W-bit word out.
// Optional even-parity check enabled by defining SERIAL_WORD_COLLECTOR_PARITY_EN.
module serial_word_collector
  import serial_word_collector_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  input  logic         in_bit,
  output logic         in_ready,
  output logic         word_valid,
  output logic [W-1:0] word,
  input  logic         word_ready,
  output logic         par_err
);

  localparam int CW = $clog2(W);

  st_t          state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0] shift_q;
  logic [W-1:0] word_q;
  logic         valid_q;
  logic [W-1:0] shift_d;
  logic         accept;
  logic         last_bit;

  assign in_ready = (state_q != ST_HOLD);
  assign accept   = in_valid && in_ready;
  assign shift_d  = {shift_q[W-2:0], in_bit};
  assign last_bit = (cnt_q == CW'(W - 1));

`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
  logic perr_q;
`endif

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order in this block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else if (clr) begin
      // Abort wins over any handshake; the held word value itself is kept.
      state_q <= ST_COLLECT;
      cnt_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (accept) begin
            shift_q <= shift_d;
            if (last_bit) begin
              word_q <= shift_d;
              cnt_q  <= '0;
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_HOLD;
              valid_q <= 1'b1;
`endif
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
        ST_PARITY: begin
          if (accept) begin
            state_q <= ST_HOLD;
            valid_q <= 1'b1;
            perr_q  <= ^{word_q, in_bit};
          end
        end
`endif
        ST_HOLD: begin
          if (word_ready) begin
            state_q <= ST_COLLECT;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_COLLECT;
          cnt_q   <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign word_valid = valid_q;
  assign word       = word_q;

`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
  assign par_err = perr_q;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed scoreboard bench for serial_word_collector (W = 7), with the popcount
// of each delivered word checked as the chained sum stage would see it.
module tb_serial_word_collector;

  localparam int W = 7;
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
  localparam int PER = W + 2;
`else
  localparam int PER = W + 1;
`endif

  typedef struct {
    logic [W-1:0] word;
    int           op;
    logic         perr;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_bit = 1'b0;
  logic         in_ready;
  logic         word_valid;
  logic [W-1:0] word;
  logic         word_ready = 1'b0;
  logic         par_err;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   rises[$];
  logic prev_valid = 1'b0;

  serial_word_collector #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_ready   (in_ready),
    .word_valid (word_valid),
    .word       (word),
    .word_ready (word_ready),
    .par_err    (par_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: samples mid-low-phase, after stimulus has settled.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (word_valid && !prev_valid) rises.push_back(cyc);
    prev_valid = word_valid;
    if (rst_n && word_valid && word_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check("word", word, e.word);
        check("sum_op", $countones(word), e.op);
        check("par_err", par_err, e.perr);
      end
    end
  end

  task automatic send_bit(input logic b);
    int n;
    @(negedge clk);
    clr = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin
      in_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    in_valid = 1'b1;
    in_bit   = b;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Sends one word MSB-first; with parity, appends a bit that makes par_err == bad_par.
  task automatic send_word(input logic [W-1:0] w, input bit gaps, input bit push, input logic bad_par);
    exp_t e;
    logic [W-1:0] tmp;
    tmp = w;
    e.word = w;
    e.op   = $countones(tmp);
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
    e.perr = bad_par;
`else
    e.perr = 1'b0;
`endif
    if (push) sb.push_back(e);
    for (int i = W - 1; i >= 0; i--) begin
      send_bit(tmp[i]);
      if (gaps && i != 0) idle();
    end
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
    if (gaps) idle();
    send_bit((^tmp) ^ bad_par);
`endif
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!word_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("word_valid_timeout", word_valid, 1);
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    check("rst_word_valid", word_valid, 0);
    check("rst_word", word, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_par_err", par_err, 0);
    rst_n = 1'b1;

    // Basic word with continuous valid and ready
    word_ready = 1'b1;
    send_word(7'b0100100, 1'b0, 1'b1, 1'b0);
    idle();
    check("basic_valid_up", word_valid, 1);
    @(negedge clk);
    check("basic_valid_one_cycle", word_valid, 0);

    // Gaps and back-pressure
    word_ready = 1'b0;
    send_word(7'b1010000, 1'b1, 1'b1, 1'b0);
    idle();
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", word_valid, 1);
      check("bp_word", word, 7'b1010000);
      check("bp_in_ready", in_ready, 0);
      in_valid = 1'b1;
      in_bit   = k[0];
      @(negedge clk);
    end
    in_valid   = 1'b0;
    word_ready = 1'b1;
    @(negedge clk);
    check("bp_consumed", word_valid, 0);

    // All ones back-to-back
    repeat (2) @(negedge clk);
    rises.delete();
    send_word(7'b1111111, 1'b0, 1'b1, 1'b0);
    send_word(7'b1111111, 1'b0, 1'b1, 1'b0);
    idle();
    repeat (3) @(negedge clk);
    check("b2b_rise_count", rises.size(), 2);
    if (rises.size() == 2) check("b2b_period", rises[1] - rises[0], PER);

    // Abort with a bit presented alongside clr
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    send_word(7'b0110101, 1'b0, 1'b1, 1'b0);
    idle();
    repeat (3) @(negedge clk);

    // Reset while holding a word
    word_ready = 1'b0;
    send_word(7'b1100110, 1'b0, 1'b0, 1'b0);
    idle();
    wait_valid();
    check("hold_word", word, 7'b1100110);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_hold_valid", word_valid, 0);
    check("rst_hold_word", word, 0);
    check("rst_hold_in_ready", in_ready, 1);
    rst_n      = 1'b1;
    word_ready = 1'b1;

`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
    // Parity good then parity bad; the bad word must still be delivered
    send_word(7'b0100100, 1'b0, 1'b1, 1'b0);
    idle();
    send_word(7'b0100100, 1'b0, 1'b1, 1'b1);
    idle();
    repeat (3) @(negedge clk);
`endif

    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_word_collector.md
# serial_word_collector

Serial-to-parallel front end for the 7-bit ones-counter stage (`sum`). It accepts a stream of single bits under a valid/ready handshake, assembles them MSB-first into a W-bit word, and presents that word on a registered valid/ready output port. The parent wires `word` straight into `sum.inp`. The block is the sequential stage directly upstream of the combinational popcount.

## Interface
- `W`, default 7: word width. Must equal the `sum` input width. Legal range is 2..16.
- `clk`, input, 1: sole clock. All logic updates on the rising edge.
- `rst_n`, input, 1: reset. Synchronous, active-low.
- `clr`, input, 1: synchronous abort. Discards the partial word and any held word.
- `in_valid`, input, 1: `in_bit` is valid.
- `in_bit`, input, 1: serial data bit.
- `in_ready`, output, 1: the block accepts a bit this cycle.
- `word_valid`, output, 1: `word` holds a complete word.
- `word`, output, W: assembled word. The first-received bit is `word[W-1]`.
- `word_ready`, input, 1: downstream consumes `word`.
- `par_err`, output, 1: parity error flag for the held word. Meaningful only with the parity option; see Configuration.

## Operation
- States:
  - COLLECT: receiving data bits.
  - PARITY: receiving the parity bit. Exists only with the macro.
  - HOLD: presenting the word downstream.
- Reset (`rst_n`=0 at an edge) sets:
  - state = COLLECT, bit counter = 0, shift register = 0.
  - `word` = 0, `word_valid` = 0, `par_err` = 0.
- Input acceptance: a bit is accepted when `in_valid && in_ready`.
  - `in_ready` = 1 in COLLECT and PARITY, 0 in HOLD. It is a combinational decode of the state register only.
- COLLECT, on each accept:
  - shift = {shift[W-2:0], in_bit}; counter increments.
  - On the accept with counter = W-1: the full word {shift[W-2:0], in_bit} is loaded into `word`, counter resets to 0, and state moves to HOLD (or PARITY with the macro).
- HOLD:
  - `word_valid` = 1.
  - When `word_ready` = 1: state returns to COLLECT and `word_valid` drops next cycle.
  - `word` and `par_err` stay stable while `word_valid` = 1.
- `in_valid` = 0 in COLLECT: nothing changes. Gaps are allowed between any bits.
- `clr` = 1 in any state:
  - next state = COLLECT, counter = 0, `word_valid` = 0, `par_err` = 0.
  - `clr` takes priority over a simultaneous accept or output handshake. A bit presented in that same cycle is dropped.
- `rst_n` = 0 mid-word or mid-HOLD behaves identically to `clr`. It also zeroes `word`.
- Counter width is $clog2(W). It never exceeds W-1.

## Timing
- `word_valid` rises on the edge that accepts the last data bit (or the parity bit with the macro). It is visible the cycle after that accept.
- Minimum period per word is W+1 cycles (W+2 with parity): W accept cycles plus one HOLD cycle with `word_ready` = 1.
- `sum.op` is valid in the same cycle as `word_valid`, since `sum` is combinational on `word`.
- There is no bypass: a bit cannot be accepted in the same cycle that the held word is consumed.

## Configuration
- Macro: `SERIAL_WORD_COLLECTOR_PARITY_EN`.
- Defined:
  - After W data bits the FSM enters PARITY and accepts one extra bit `p`.
  - `par_err` = ^{word, p}. Even parity is expected, so any odd total flags an error.
  - `par_err` is registered together with the transition into HOLD.
  - The word is still delivered when `par_err` = 1. Discarding it is the consumer's decision.
- Undefined:
  - The PARITY state and parity logic are absent.
  - `par_err` is tied to 0.
  - COLLECT goes directly to HOLD.

## Structure
- Shared package `serial_word_collector_pkg` holds:
  - `W_DEFAULT` = 7.
  - The state enum `st_t` {ST_COLLECT, ST_PARITY, ST_HOLD}.
  - The shared constant `POP_W` = $clog2(W_DEFAULT+1) = 3, used by the `sum` output.
- No sub-module. One flat FSM with a shift register and a counter.
- `sum` is instantiated beside this block in the parent, not inside it.

## Test plan
- **Basic word:** after reset, send 0,1,0,0,1,0,0 with `in_valid` continuous and `word_ready` = 1.
  - `word_valid` = 1 for exactly one cycle, `word` = 7'b0100100.
  - Chained `sum.op` = 2.
- **Gaps and back-pressure:** send 1,0,1,0,0,0,0 with `in_valid` toggling and `word_ready` held 0 for 5 cycles.
  - `word` = 7'b1010000 stays stable with `in_ready` = 0 throughout.
  - Consumed on the first `word_ready` = 1; `op` = 2.
- **All ones back-to-back:** two consecutive words of 1111111.
  - Each delivered as 7'b1111111 with `op` = 7.
  - Period between the two `word_valid` rises is exactly 8 cycles.
- **Abort:** send 3 bits, pulse `clr` together with a 4th bit, then send 0,1,1,0,1,0,1.
  - Delivered `word` = 7'b0110101, `op` = 4; no stale bits.
- **Reset mid-HOLD:** hold a word with `word_ready` = 0, then pull `rst_n` low for 1 cycle.
  - Next cycle: `word_valid` = 0, `word` = 0, `in_ready` = 1.
- **Parity (macro defined):**
  - 0100100 followed by parity 0 gives `par_err` = 0.
  - 0100100 followed by parity 1 gives `par_err` = 1, and the word is still delivered.
